// File: rtl/put_command_fsm_if.sv
// Command-buffer producer bus: host request fields in, buffer write port out.
// The slave side is the put_command_fsm; the master side is the host/buffer.
interface put_command_fsm_if #(
    parameter int buffer_size = 1024
);
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < value) r = i + 1;
        return (value <= 1) ? 1 : r;
    endfunction

    localparam int A = log2(buffer_size);

    logic         start_put_cmd;
    logic [7:0]   instr;
    logic [2:0]   arg1;
    logic [4:0]   arg2;
    logic [A-1:0] rd_addr_command;
    logic         en_wr_cmd;
    logic [A-1:0] wr_addr_command;
    logic [15:0]  wr_data_command;
    logic         done_put_cmd;
    logic         cmd_rejected;

    modport master (
        output start_put_cmd, instr, arg1, arg2, rd_addr_command,
        input  en_wr_cmd, wr_addr_command, wr_data_command,
        input  done_put_cmd, cmd_rejected
    );

    modport slave (
        input  start_put_cmd, instr, arg1, arg2, rd_addr_command,
        output en_wr_cmd, wr_addr_command, wr_data_command,
        output done_put_cmd, cmd_rejected
    );
endinterface

// File: rtl/put_command_fsm.sv
// Command-buffer producer: packs a command, checks for space against the
// consumer read pointer, writes one word, and pulses done (or rejected).
module put_command_fsm #(
    parameter int buffer_size = 1024
) (
    input  logic             clk,
    input  logic             rst,
    put_command_fsm_if.slave bus
);
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < value) r = i + 1;
        return (value <= 1) ? 1 : r;
    endfunction

    localparam int A = log2(buffer_size);
    localparam logic [A-1:0] LAST = A'(buffer_size - 1);

    typedef enum logic [1:0] {
        S_START,
        S_PACK,
        S_WRITE,
        S_END
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [A-1:0] wr_addr;
    logic [A-1:0] next_ptr;
    logic [15:0]  wr_data;
    logic         rejected;
    logic         full;

    // Wrap explicitly so non-power-of-two depths work.
    assign next_ptr = (wr_addr == LAST) ? '0 : wr_addr + 1'b1;
    assign full     = (next_ptr == bus.rd_addr_command);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_START;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_START;
        unique case (state)
            S_START: state_nxt = bus.start_put_cmd ? S_PACK : S_START;
            S_PACK:  state_nxt = full ? S_END : S_WRITE;
            S_WRITE: state_nxt = S_END;
            S_END:   state_nxt = S_START;
            default: state_nxt = S_START;
        endcase
    end

    always_comb begin
        bus.en_wr_cmd    = 1'b0;
        bus.done_put_cmd = 1'b0;
        unique case (state)
            S_WRITE: bus.en_wr_cmd    = 1'b1;
            S_END:   bus.done_put_cmd = 1'b1;
            default: ;
        endcase
    end

    // 8'hFF in the opcode field marks the reset word as an invalid command.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_addr  <= '0;
            wr_data  <= 16'hFF00;
            rejected <= 1'b0;
        end else begin
            if (state == S_START && bus.start_put_cmd)
                wr_data <= {bus.instr, bus.arg1, bus.arg2};
            if (state == S_PACK)
                rejected <= full;
            if (state == S_WRITE)
                wr_addr <= next_ptr;
        end
    end

    assign bus.wr_addr_command = wr_addr;
    assign bus.wr_data_command = wr_data;
    assign bus.cmd_rejected    = rejected;
endmodule
